vreg_dump: RTL

Post-run readback engine for the vmips SIMD core. It watches the instruction bus for the halt condition (all-zero instruction after the program has started). It then reads vector registers 1..6 from the four lane register files (x, y, z, w) through their shared read port. Each lane word is streamed out as one valid/ready beat to a host-side sink, so results come out of the core in hardware instead of being probed hierarchically.

---
 rtl/vreg_dump_pkg.sv | 21 ++
 rtl/vreg_dump_if.sv | 33 +++
 rtl/vreg_dump_buf.sv | 35 +++
 rtl/vreg_dump.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vreg_dump_pkg.sv
// Shared types and constants for the vmips vector register dump engine.
// Optional checksum beat: define VREG_DUMP_CSUM_EN.
package vmips_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    SEND,
    CSUM,
    DONE
  } dump_state_e;

  localparam logic [1:0] LANE_X = 2'd0;
  localparam logic [1:0] LANE_Y = 2'd1;
  localparam logic [1:0] LANE_Z = 2'd2;
  localparam logic [1:0] LANE_W = 2'd3;

  localparam logic [31:0] HALT_INST = 32'd0;

endpackage

// File: rtl/vreg_dump_if.sv
// Valid/ready beat stream from the dump engine to the host sink.
// One beat carries one lane word plus its register/lane tag.
interface vreg_dump_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);

  logic               m_valid;
  logic               m_ready;
  logic [DATA_W-1:0]  m_data;
  logic [RADDR_W-1:0] m_reg;
  logic [1:0]         m_lane;
  logic               m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_reg,
    output m_lane,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_reg,
    input  m_lane,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/vreg_dump_buf.sv
// Four-lane capture buffer plus lane mux; isolates beats in flight
// from later register file writes.
module vreg_dump_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [DATA_W-1:0] z_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [1:0]        lane_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] buf_q [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      buf_q[2] <= '0;
      buf_q[3] <= '0;
    end else if (load_i) begin
      buf_q[0] <= x_i;
      buf_q[1] <= y_i;
      buf_q[2] <= z_i;
      buf_q[3] <= w_i;
    end
  end

  always_comb data_o = buf_q[lane_i];

endmodule

// File: rtl/vreg_dump.sv
// Post-halt readback of vector registers FIRST_REG..LAST_REG, all lanes.
// Define VREG_DUMP_CSUM_EN to append an XOR checksum beat.
module vreg_dump
  import vmips_dump_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RADDR_W   = 5,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        inst,
  output logic               rd_en,
  output logic [RADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]  rd_data_x,
  input  logic [DATA_W-1:0]  rd_data_y,
  input  logic [DATA_W-1:0]  rd_data_z,
  input  logic [DATA_W-1:0]  rd_data_w,
  vreg_dump_if.master        m,
  output logic               busy,
  output logic               done
);

  localparam logic [RADDR_W-1:0] FIRST_R = RADDR_W'(FIRST_REG);
  localparam logic [RADDR_W-1:0] LAST_R  = RADDR_W'(LAST_REG);

  dump_state_e        state_q, state_d;
  logic               armed_q, armed_d;
  logic [RADDR_W-1:0] reg_q, reg_d;
  logic [1:0]         lane_q, lane_d;
  logic               load;
  logic [DATA_W-1:0]  buf_data;
  logic               lane_end;
  logic               reg_end;
`ifdef VREG_DUMP_CSUM_EN
  logic [DATA_W-1:0]  csum_q, csum_d;
`endif

  vreg_dump_buf #(.DATA_W(DATA_W)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .x_i    (rd_data_x),
    .y_i    (rd_data_y),
    .z_i    (rd_data_z),
    .w_i    (rd_data_w),
    .lane_i (lane_q),
    .data_o (buf_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      reg_q   <= '0;
      lane_q  <= LANE_X;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      reg_q   <= reg_d;
      lane_q  <= lane_d;
    end
  end

`ifdef VREG_DUMP_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  assign lane_end = (lane_q == LANE_W);
  assign reg_end  = (reg_q == LAST_R);

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    reg_d     = reg_q;
    lane_d    = lane_q;
    load      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    m.m_valid = 1'b0;
    m.m_data  = '0;
    m.m_reg   = '0;
    m.m_lane  = LANE_X;
    m.m_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
`ifdef VREG_DUMP_CSUM_EN
    csum_d    = csum_q;
`endif
    if (inst != HALT_INST) armed_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (armed_q && inst == HALT_INST) begin
          state_d = READ;
          reg_d   = FIRST_R;
`ifdef VREG_DUMP_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      READ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = reg_q;
        state_d = CAPT;
      end
      CAPT: begin
        busy    = 1'b1;
        load    = 1'b1;
        lane_d  = LANE_X;
        state_d = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        m.m_valid = 1'b1;
        m.m_data  = buf_data;
        m.m_reg   = reg_q;
        m.m_lane  = lane_q;
`ifndef VREG_DUMP_CSUM_EN
        m.m_last  = lane_end && reg_end;
`endif
        if (m.m_ready) begin
`ifdef VREG_DUMP_CSUM_EN
          csum_d = csum_q ^ buf_data;
`endif
          if (!lane_end) begin
            lane_d = lane_q + 2'd1;
          end else if (!reg_end) begin
            reg_d   = reg_q + RADDR_W'(1);
            state_d = READ;
          end else begin
`ifdef VREG_DUMP_CSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef VREG_DUMP_CSUM_EN
      CSUM: begin
        busy      = 1'b1;
        m.m_valid = 1'b1;
        m.m_data  = csum_q;
        m.m_reg   = LAST_R;
        m.m_lane  = LANE_X;
        m.m_last  = 1'b1;
        if (m.m_ready) state_d = DONE;
      end
`endif
      DONE: begin
        done = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
